// File: rtl/vx_tcu_tfr_mul_pipe.sv
// Tensor-core multiply front end: per-lane FP16/BF16/TF32 operand decode,
// exponent sum, exception flags and mantissa product in a stallable pipeline.
module vx_tcu_tfr_mul_pipe #(
  parameter int N = 2,
  parameter int TCK = 2 * N,
  parameter int W = 25,
  parameter int WA = 28,
  parameter int EXP_W = 10,
  parameter int LATENCY = 2,
  parameter bit BF16_EN = 1'b1,
  parameter bit TF32_EN = 1'b1,
  parameter int TCU_MAX_INPUTS = 32,
  parameter logic [2:0] TCU_FP16_ID = 3'd1,
  parameter logic [2:0] TCU_BF16_ID = 3'd2,
  parameter logic [2:0] TCU_TF32_ID = 3'd3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [31:0]               req_id_in,
  input  logic [TCU_MAX_INPUTS-1:0] vld_mask,
  input  logic [2:0]                fmt_f,
  input  logic [N*32-1:0]           a_row,
  input  logic [N*32-1:0]           b_col,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [31:0]               req_id_out,
  output logic [TCK*25-1:0]         result_sig,
  output logic [TCK*EXP_W-1:0]      result_exp,
  output logic [TCK-1:0]            exc_nan,
  output logic [TCK-1:0]            exc_inf,
  output logic [TCK-1:0]            exc_sign,
  output logic                      fmt_err
);

  localparam int BIAS_K = 255 + WA - W;
  localparam logic [7:0] BIAS_H = 8'(BIAS_K - 30);
  localparam logic [7:0] BIAS_W = 8'(BIAS_K - 254);

  typedef enum logic [1:0] {F_BAD, F_FP16, F_BF16, F_TF32} fsel_e;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [10:0] m;
    logic        z;
    logic        inf;
    logic        nan;
  } op_t;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               id;
    logic                      ferr;
    logic                      bf;
    logic [TCK-1:0][10:0]      ma;
    logic [TCK-1:0][10:0]      mb;
    logic [TCK-1:0][EXP_W-1:0] exp;
    logic [TCK-1:0]            nan;
    logic [TCK-1:0]            inf;
    logic [TCK-1:0]            sgn;
  } dec_t;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               id;
    logic                      ferr;
    logic [TCK-1:0][24:0]      sig;
    logic [TCK-1:0][EXP_W-1:0] exp;
    logic [TCK-1:0]            nan;
    logic [TCK-1:0]            inf;
    logic [TCK-1:0]            sgn;
  } res_t;

  function automatic op_t unpack_op(
    input logic [31:0] w,
    input logic        hi,
    input fsel_e       f
  );
    logic [15:0] h;
    logic [9:0]  fr;
    logic        emax;
    op_t         o;
    h = hi ? w[31:16] : w[15:0];
    o = '0;
    unique case (f)
      F_BF16: begin
        o.s  = h[15];
        o.e  = h[14:7];
        fr   = {3'b0, h[6:0]};
        emax = &h[14:7];
        o.m  = {3'b0, |h[14:7], h[6:0]};
      end
      F_TF32: begin
        o.s  = w[31];
        o.e  = w[30:23];
        fr   = w[9:0];
        emax = &w[30:23];
        o.m  = {|w[30:23], w[9:0]};
      end
      default: begin
        o.s  = h[15];
        o.e  = {3'b0, h[14:10]};
        fr   = h[9:0];
        emax = &h[14:10];
        o.m  = {|h[14:10], h[9:0]};
      end
    endcase
    o.z   = (o.e == 8'd0) && (fr == 10'd0);
    o.inf = emax && (fr == 10'd0);
    o.nan = emax && (fr != 10'd0);
    // subnormals share the exponent of the smallest normal
    if (o.e == 8'd0) o.e = 8'd1;
    return o;
  endfunction

  function automatic res_t mul(input dec_t d);
    res_t        r;
    logic [21:0] p;
    r       = '0;
    r.valid = d.valid;
    r.id    = d.id;
    r.ferr  = d.ferr;
    r.exp   = d.exp;
    r.nan   = d.nan;
    r.inf   = d.inf;
    r.sgn   = d.sgn;
    for (int i = 0; i < TCK; i++) begin
      p = 22'(d.ma[i]) * 22'(d.mb[i]);
      r.sig[i] = d.bf ? {d.sgn[i], p[15:0], 8'b0}
                      : {d.sgn[i], p, 2'b0};
    end
    return r;
  endfunction

  fsel_e fsel;
  dec_t  dec;
  op_t   oa;
  op_t   ob;
  logic  en;
  logic  tf_odd;
  logic  infz;
  logic  advance;
  res_t  out_q;

  always_comb begin
    fsel = F_BAD;
    unique case (1'b1)
      fmt_f == TCU_FP16_ID:            fsel = F_FP16;
      BF16_EN && fmt_f == TCU_BF16_ID: fsel = F_BF16;
      TF32_EN && fmt_f == TCU_TF32_ID: fsel = F_TF32;
      default: ;
    endcase
  end

  always_comb begin
    dec       = '0;
    oa        = '0;
    ob        = '0;
    en        = 1'b0;
    tf_odd    = 1'b0;
    infz      = 1'b0;
    dec.valid = valid_in;
    dec.id    = req_id_in;
    dec.ferr  = (fsel == F_BAD);
    dec.bf    = (fsel == F_BF16);
    for (int i = 0; i < TCK; i++) begin
      oa     = unpack_op(a_row[32*(i/2) +: 32], 1'(i % 2), fsel);
      ob     = unpack_op(b_col[32*(i/2) +: 32], 1'(i % 2), fsel);
      en     = vld_mask[4*i];
      tf_odd = (fsel == F_TF32) && (i % 2 == 1);
      infz   = (oa.inf && ob.z) || (oa.z && ob.inf);
      if (fsel != F_BAD && !tf_odd) begin
        dec.ma[i]  = oa.m;
        dec.mb[i]  = ob.m;
        dec.sgn[i] = oa.s ^ ob.s;
        dec.nan[i] = en && (oa.nan || ob.nan || infz);
        dec.inf[i] = en && (oa.inf || ob.inf) && !infz;
        if (en && !oa.z && !ob.z)
          dec.exp[i] = EXP_W'(fsel == F_FP16 ? BIAS_H : BIAS_W)
                     + EXP_W'(oa.e) + EXP_W'(ob.e);
      end else begin
        dec.nan[i] = (fsel == F_BAD) && en;
      end
    end
  end

  assign advance  = ready_out || !out_q.valid;
  assign ready_in = advance;

  if (LATENCY == 1) begin : g_l1
    always_ff @(posedge clk or posedge reset) begin
      if (reset) out_q <= '0;
      else if (advance) out_q <= mul(dec);
    end
  end else begin : g_ln
    dec_t                    d1_q;
    res_t [LATENCY-2:0]      pipe_q;
    // stage 1 holds decoded operands; the product lands in stage 2
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        d1_q   <= '0;
        pipe_q <= '0;
      end else if (advance) begin
        d1_q      <= dec;
        pipe_q[0] <= mul(d1_q);
        for (int k = 1; k < LATENCY - 1; k++)
          pipe_q[k] <= pipe_q[k-1];
      end
    end
    assign out_q = pipe_q[LATENCY-2];
  end

  assign valid_out  = out_q.valid;
  assign req_id_out = out_q.id;
  assign result_sig = out_q.sig;
  assign result_exp = out_q.exp;
  assign exc_nan    = out_q.nan;
  assign exc_inf    = out_q.inf;
  assign exc_sign   = out_q.sgn;
  assign fmt_err    = out_q.ferr;

endmodule

// File: tb/tb_vx_tcu_tfr_mul_pipe.sv
// Directed and randomised bench for vx_tcu_tfr_mul_pipe with a
// transaction-level reference model of the lane arithmetic and pipeline.
module tb_vx_tcu_tfr_mul_pipe;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] req_id_in;
  logic [31:0] vld_mask;
  logic [2:0]  fmt_f;
  logic [63:0] a_row;
  logic [63:0] b_col;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] req_id_out;
  logic [99:0] result_sig;
  logic [39:0] result_exp;
  logic [3:0]  exc_nan;
  logic [3:0]  exc_inf;
  logic [3:0]  exc_sign;
  logic        fmt_err;

  vx_tcu_tfr_mul_pipe #(.N(2), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in),
    .req_id_in(req_id_in), .vld_mask(vld_mask), .fmt_f(fmt_f),
    .a_row(a_row), .b_col(b_col),
    .valid_out(valid_out), .ready_out(ready_out),
    .req_id_out(req_id_out), .result_sig(result_sig),
    .result_exp(result_exp), .exc_nan(exc_nan), .exc_inf(exc_inf),
    .exc_sign(exc_sign), .fmt_err(fmt_err)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] id;
    logic [99:0] sig;
    logic [39:0] ex;
    logic [3:0]  nan;
    logic [3:0]  inf;
    logic [3:0]  sgn;
    logic        ferr;
  } exp_t;

  exp_t        slot [LAT];
  int          errs = 0;
  int          checks = 0;
  logic [31:0] sent_q [$];
  logic [31:0] got_q [$];
  logic [15:0] spc [11] = '{16'h0000, 16'h8000, 16'h3C00, 16'h7C00,
                            16'h7E01, 16'h7F80, 16'h7FC1, 16'h0001,
                            16'h0080, 16'hFC00, 16'hFF80};
  logic [2:0]  fmts [8] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd7, 3'd0};

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] req);
    checks++;
    assert (obs === req) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic void split(input logic [2:0] fmt, input logic [63:0] x,
                                input int i, output int unsigned s,
                                output int unsigned ev, output int unsigned mv,
                                output bit z, output bit inf, output bit nan);
    int unsigned w, e, f, emax, fw;
    logic [63:0] sh;
    if (fmt == 3'd3) begin
      sh = x >> (32 * (i / 2));
      w = sh[31:0];
      s = w >> 31; e = (w >> 23) & 255; f = w & 1023;
      emax = 255; fw = 10;
    end else begin
      sh = x >> (32 * (i / 2) + 16 * (i % 2));
      w = {16'h0, sh[15:0]};
      s = w >> 15;
      if (fmt == 3'd1) begin
        e = (w >> 10) & 31; f = w & 1023; emax = 31; fw = 10;
      end else begin
        e = (w >> 7) & 255; f = w & 127; emax = 255; fw = 7;
      end
    end
    z   = (e == 0) && (f == 0);
    inf = (e == emax) && (f == 0);
    nan = (e == emax) && (f != 0);
    ev  = (e == 0) ? 1 : e;
    mv  = f + ((e != 0) ? (1 << fw) : 0);
  endfunction

  function automatic exp_t model(input logic v, input logic [31:0] id,
                                 input logic [31:0] mask, input logic [2:0] fmt,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t r;
    bit legal, bf, en, za, zb, ia, ib, na, nb, infz;
    int unsigned sa, sb, ea, eb, ma, mb, prod, sig, bias;
    r = '0;
    r.v = v;
    r.id = id;
    legal = (fmt == 3'd1) || (fmt == 3'd2) || (fmt == 3'd3);
    r.ferr = !legal;
    bf = (fmt == 3'd2);
    bias = (fmt == 3'd1) ? ((258 - 2 * 15) & 255) : ((258 - 2 * 127) & 255);
    for (int i = 0; i < 4; i++) begin
      en = mask[4*i];
      if (!legal) begin
        r.nan[i] = en;
      end else if (!(fmt == 3'd3 && i % 2 == 1)) begin
        split(fmt, a, i, sa, ea, ma, za, ia, na);
        split(fmt, b, i, sb, eb, mb, zb, ib, nb);
        infz = (ia && zb) || (za && ib);
        prod = ma * mb;
        sig = ((sa ^ sb) << 24) |
              (bf ? ((prod & 32'hFFFF) << 8) : ((prod & 32'h3FFFFF) << 2));
        r.sig[25*i +: 25] = 25'(sig);
        r.ex[10*i +: 10] = (en && !za && !zb) ? 10'((bias + ea + eb) % 1024) : 10'd0;
        r.nan[i] = en && (na || nb || infz);
        r.inf[i] = en && (ia || ib) && !infz;
        r.sgn[i] = 1'(sa ^ sb);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] rword();
    logic [63:0] w;
    for (int h = 0; h < 4; h++)
      w[16*h +: 16] = ($urandom_range(0, 2) == 0) ? spc[$urandom_range(0, 10)]
                                                  : 16'($urandom);
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] id, input logic [31:0] m,
                       input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    valid_in = v; req_id_in = id; vld_mask = m; fmt_f = f; a_row = a; b_col = b;
  endtask

  task automatic clear_model();
    for (int k = 0; k < LAT; k++) slot[k] = '0;
  endtask

  task automatic cycle(output logic acc);
    logic adv;
    exp_t o;
    #1;
    o = slot[LAT-1];
    adv = ready_out || !o.v;
    chk("ready_in", ready_in, adv);
    chk("valid_out", valid_out, o.v);
    if (o.v) begin
      chk("req_id_out", req_id_out, o.id);
      chk("result_sig", result_sig, o.sig);
      chk("result_exp", result_exp, o.ex);
      chk("exc_nan", exc_nan, o.nan);
      chk("exc_inf", exc_inf, o.inf);
      chk("exc_sign", exc_sign, o.sgn);
      chk("fmt_err", fmt_err, o.ferr);
      if (ready_out) got_q.push_back(req_id_out);
    end
    acc = valid_in && adv;
    if (acc) sent_q.push_back(req_id_in);
    if (adv) begin
      for (int k = LAT - 1; k > 0; k--) slot[k] = slot[k-1];
      slot[0] = model(valid_in, req_id_in, vld_mask, fmt_f, a_row, b_col);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   n;
    int   c;
    clear_model();
    reset = 1'b1;
    ready_out = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 3'd1, 64'h0, 64'h0);
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_ready_in", ready_in, 1'b1);
    chk("rst_sig", result_sig, 100'h0);
    chk("rst_exp", result_exp, 40'h0);
    chk("rst_fmt_err", fmt_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // FP16 1.0 x 1.0 on every lane
    drive(1'b1, 32'h100, 32'hFFFF_FFFF, 3'd1, {4{16'h3C00}}, {4{16'h3C00}});
    cycle(acc);
    drive(1'b0, 32'h0, 32'h0, 3'd1, 64'h0, 64'h0);
    cycle(acc);
    chk("one_valid", valid_out, 1'b1);
    chk("one_exp", result_exp, {4{10'd258}});
    chk("one_sig", result_sig, {4{25'h0400000}});
    chk("one_exc", {exc_nan, exc_inf}, 8'h00);
    cycle(acc);

    // Inf x 0 and Inf x 1.0
    drive(1'b1, 32'h101, 32'hFFFF_FFFF, 3'd1, {32'h0, 32'h7C007C00},
          {32'h0, 32'h3C000000});
    cycle(acc);
    drive(1'b0, 32'h0, 32'h0, 3'd1, 64'h0, 64'h0);
    cycle(acc);
    chk("infz_nan0", exc_nan[0], 1'b1);
    chk("infz_inf0", exc_inf[0], 1'b0);
    chk("inf1_inf", exc_inf[1], 1'b1);
    chk("inf1_nan", exc_nan[1], 1'b0);
    cycle(acc);

    // TF32 1.0 x -2.0
    drive(1'b1, 32'h102, 32'hFFFF_FFFF, 3'd3, {32'h0, 32'h3F800000},
          {32'h0, 32'hC0000000});
    cycle(acc);
    drive(1'b0, 32'h0, 32'h0, 3'd1, 64'h0, 64'h0);
    cycle(acc);
    chk("tf32_exp0", result_exp[9:0], 10'd259);
    chk("tf32_sign0", exc_sign[0], 1'b1);
    chk("tf32_sig0", result_sig[24:0], 25'h1400000);
    chk("tf32_exp1", result_exp[19:10], 10'd0);
    chk("tf32_exc1", {exc_nan[1], exc_inf[1]}, 2'b00);
    cycle(acc);

    // unsupported format followed directly by a legal one
    drive(1'b1, 32'h103, 32'h0000_0011, 3'd7, rword(), rword());
    cycle(acc);
    drive(1'b1, 32'h104, 32'hFFFF_FFFF, 3'd1, {4{16'h3C00}}, {4{16'h3C00}});
    cycle(acc);
    drive(1'b0, 32'h0, 32'h0, 3'd1, 64'h0, 64'h0);
    chk("bad_fmt_err", fmt_err, 1'b1);
    chk("bad_nan", exc_nan, 4'b0011);
    chk("bad_sig", result_sig, 100'h0);
    chk("bad_exp", result_exp, 40'h0);
    cycle(acc);
    chk("after_bad_fmt_err", fmt_err, 1'b0);
    chk("after_bad_exp", result_exp, {4{10'd258}});
    cycle(acc);

    // back-to-back stream with a three-cycle downstream stall
    sent_q.delete();
    got_q.delete();
    n = 0;
    c = 0;
    while (n < 8 && c < 40) begin
      ready_out = !(c >= 3 && c <= 5);
      drive(1'b1, 32'h300 + 32'(n), 32'hFFFF_FFFF, 3'd1, rword(), rword());
      cycle(acc);
      if (acc) n++;
      c++;
    end
    ready_out = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 3'd1, 64'h0, 64'h0);
    repeat (LAT + 2) cycle(acc);
    chk("stream_count", 32'(got_q.size()), 32'd8);
    for (int j = 0; j < 8 && j < got_q.size(); j++)
      chk("stream_order", got_q[j], 32'h300 + 32'(j));

    // random traffic, formats, masks and back-pressure
    for (int t = 0; t < 400; t++) begin
      ready_out = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), $urandom, $urandom,
            fmts[$urandom_range(0, 7)], rword(), rword());
      cycle(acc);
    end
    ready_out = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 3'd1, 64'h0, 64'h0);
    repeat (LAT + 1) cycle(acc);

    // reset with two transactions in flight
    drive(1'b1, 32'h500, 32'hFFFF_FFFF, 3'd1, rword(), rword());
    cycle(acc);
    drive(1'b1, 32'h501, 32'hFFFF_FFFF, 3'd2, rword(), rword());
    cycle(acc);
    chk("pre_rst_valid", valid_out, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", valid_out, 1'b0);
    chk("async_rst_sig", result_sig, 100'h0);
    chk("async_rst_id", req_id_out, 32'h0);
    chk("async_rst_fmt_err", fmt_err, 1'b0);
    chk("async_rst_ready", ready_in, 1'b1);
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    drive(1'b1, 32'h502, 32'hFFFF_FFFF, 3'd1, {4{16'h3C00}}, {4{16'h4000}});
    cycle(acc);
    drive(1'b0, 32'h0, 32'h0, 3'd1, 64'h0, 64'h0);
    repeat (LAT + 1) cycle(acc);
    chk("post_rst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("post_rst_first", got_q[0], 32'h502);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
